// File: rtl/bp_pkg.sv
// Shared encodings and helpers for the branch prediction unit.
package bp_pkg;

    // 2-bit saturating counter states
    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Sequential PC step
    localparam int unsigned PC_INC = 32'd4;

    // Counter write operations requested of the target buffer
    typedef enum logic [1:0] {
        CTR_HOLD = 2'b00,
        CTR_INC  = 2'b01,
        CTR_DEC  = 2'b10,
        CTR_SET  = 2'b11
    } ctr_op_e;

    // Saturating step of a 2-bit direction counter
    function automatic logic [1:0] sat_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == ST) ? ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BHT/BTB storage: one combinational read port, one clocked write port.
// Valid bits and counters are reset; tags and targets are only meaningful when valid.
module branch_target_buffer
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int TAG_BITS   = PC_WIDTH - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [PC_WIDTH-1:0]   rd_target,
    output logic [1:0]            rd_ctr,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  ctr_op_e               wr_ctr_op,
    input  logic                  wr_alloc,
    input  logic                  wr_inval,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [PC_WIDTH-1:0]   wr_target
);

    localparam int ENTRIES = 2 ** INDEX_BITS;

    logic                valid_r  [ENTRIES];
    logic [1:0]          ctr_r    [ENTRIES];
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [PC_WIDTH-1:0] target_r [ENTRIES];

    // Read port: raw pre-update contents, no write bypass
    always_comb begin
        rd_valid  = valid_r[rd_idx];
        rd_tag    = tag_r[rd_idx];
        rd_target = target_r[rd_idx];
        rd_ctr    = ctr_r[rd_idx];
    end

    // Valid bits and direction counters, cleared to invalid/WNT on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                ctr_r[i]   <= WNT;
            end
        end else begin
            if (wr_alloc) begin
                valid_r[wr_idx] <= 1'b1;
            end else if (wr_inval) begin
                valid_r[wr_idx] <= 1'b0;
            end
            case (wr_ctr_op)
                CTR_INC:  ctr_r[wr_idx] <= sat_update(ctr_r[wr_idx], 1'b1);
                CTR_DEC:  ctr_r[wr_idx] <= sat_update(ctr_r[wr_idx], 1'b0);
                CTR_SET:  ctr_r[wr_idx] <= ST;
                default:  ctr_r[wr_idx] <= ctr_r[wr_idx];
            endcase
        end
    end

    // Tag and target payload, written only on allocation
    always_ff @(posedge clk) begin
        if (wr_alloc && !reset) begin
            tag_r[wr_idx]    <= wr_tag;
            target_r[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: IF-side lookup, EX-side resolve/flush and redirect,
// table training and a saturating mispredict statistics counter.
module branch_predict_unit
    import bp_pkg::*;
#(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [PC_WIDTH-1:0]  pc_if,
    output logic                 predict_taken_if,
    output logic [PC_WIDTH-1:0]  predict_target_if,
    input  logic                 ex_valid,
    input  logic                 branch_ex,
    input  logic                 jump_ex,
    input  logic [PC_WIDTH-1:0]  pc_ex,
    input  logic                 taken_ex,
    input  logic [PC_WIDTH-1:0]  target_ex,
    input  logic                 pred_taken_ex,
    input  logic [PC_WIDTH-1:0]  pred_target_ex,
    output logic                 wrong_prediction,
    output logic [PC_WIDTH-1:0]  redirect_pc,
    output logic [CNT_WIDTH-1:0] mispredict_count
);

    localparam int TAG_BITS = PC_WIDTH - INDEX_BITS - 2;
    localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(PC_INC);

    logic                  rd_valid_s;
    logic [TAG_BITS-1:0]   rd_tag_s;
    logic [PC_WIDTH-1:0]   rd_target_s;
    logic [1:0]            rd_ctr_s;
    logic                  hit_s;
    logic                  act_taken_s;
    logic                  cf_s;
    logic                  stale_s;
    ctr_op_e               ctr_op_s;
    logic                  alloc_s;
    logic [CNT_WIDTH-1:0]  mispredict_count_r;

    branch_target_buffer #(
        .PC_WIDTH   (PC_WIDTH),
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_btb (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pc_if[INDEX_BITS+1:2]),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_target (rd_target_s),
        .rd_ctr    (rd_ctr_s),
        .wr_idx    (pc_ex[INDEX_BITS+1:2]),
        .wr_ctr_op (ctr_op_s),
        .wr_alloc  (alloc_s),
        .wr_inval  (stale_s),
        .wr_tag    (pc_ex[PC_WIDTH-1:INDEX_BITS+2]),
        .wr_target (target_ex)
    );

    // Fetch-side prediction from the current table contents
    always_comb begin
        hit_s            = rd_valid_s && (rd_tag_s == pc_if[PC_WIDTH-1:INDEX_BITS+2]);
        predict_taken_if = hit_s && rd_ctr_s[1];
        if (predict_taken_if) begin
            predict_target_if = rd_target_s;
        end else begin
            predict_target_if = pc_if + PC_STEP;
        end
    end

    // EX-side resolve: flush decision, redirect target and training request
    always_comb begin
        act_taken_s = jump_ex | (branch_ex & taken_ex);
        cf_s        = ex_valid & (branch_ex | jump_ex);
        // A non-control instruction that was predicted taken hit an aliased entry
        stale_s     = ex_valid & ~branch_ex & ~jump_ex & pred_taken_ex;
        wrong_prediction = (cf_s & (act_taken_s != pred_taken_ex))
                         | (cf_s & act_taken_s & (target_ex != pred_target_ex))
                         | stale_s;
        if (act_taken_s) begin
            redirect_pc = target_ex;
        end else begin
            redirect_pc = pc_ex + PC_STEP;
        end
        ctr_op_s = CTR_HOLD;
        alloc_s  = 1'b0;
        if (cf_s) begin
            if (jump_ex) begin
                ctr_op_s = CTR_SET;
                alloc_s  = 1'b1;
            end else if (taken_ex) begin
                ctr_op_s = CTR_INC;
                alloc_s  = 1'b1;
            end else begin
                ctr_op_s = CTR_DEC;
                alloc_s  = 1'b0;
            end
        end else begin
            ctr_op_s = CTR_HOLD;
            alloc_s  = 1'b0;
        end
    end

    // Mispredict statistics, saturating at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mispredict_count_r <= {CNT_WIDTH{1'b0}};
        end else if (wrong_prediction && (mispredict_count_r != {CNT_WIDTH{1'b1}})) begin
            mispredict_count_r <= mispredict_count_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign mispredict_count = mispredict_count_r;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: the driver pushes model-predicted responses, a negedge monitor compares.
module tb_branch_predict_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_if;
    logic        predict_taken_if;
    logic [31:0] predict_target_if;
    logic        ex_valid, branch_ex, jump_ex, taken_ex, pred_taken_ex;
    logic [31:0] pc_ex, target_ex, pred_target_ex;
    logic        wrong_prediction;
    logic [31:0] redirect_pc;
    logic [15:0] mispredict_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        ptk;
        logic [31:0] ptgt;
        logic        wrong;
        logic [31:0] redir;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    // Reference state: plain arrays indexed by table slot
    int          m_ctr [16];
    logic [25:0] m_tag [16];
    logic [31:0] m_tgt [16];
    bit          m_val [16];
    int          m_cnt;

    always #5 clk = ~clk;

    branch_predict_unit dut (
        .clk(clk), .reset(reset), .pc_if(pc_if),
        .predict_taken_if(predict_taken_if), .predict_target_if(predict_target_if),
        .ex_valid(ex_valid), .branch_ex(branch_ex), .jump_ex(jump_ex), .pc_ex(pc_ex),
        .taken_ex(taken_ex), .target_ex(target_ex), .pred_taken_ex(pred_taken_ex),
        .pred_target_ex(pred_target_ex), .wrong_prediction(wrong_prediction),
        .redirect_pc(redirect_pc), .mispredict_count(mispredict_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) begin
            m_ctr[i] = 1;
            m_val[i] = 1'b0;
            m_tag[i] = '0;
            m_tgt[i] = '0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_predict(input logic [31:0] pc, output logic tk, output logic [31:0] tg);
        int i;
        i  = int'(pc[5:2]);
        tk = m_val[i] && (m_tag[i] == pc[31:6]) && (m_ctr[i] >= 2);
        tg = tk ? m_tgt[i] : pc + 32'd4;
    endfunction

    // Builds the expected response from the rules, then advances the model past the clock edge
    function automatic exp_t model_step(input logic [31:0] pif, input logic v, b, j,
                                        input logic [31:0] pex, input logic tk,
                                        input logic [31:0] tgt, input logic ptk,
                                        input logic [31:0] ptgt, input bit do_update);
        exp_t e;
        logic actual;
        bit   is_cf;
        int   i;
        model_predict(pif, e.ptk, e.ptgt);
        actual  = j || (b && tk);
        is_cf   = v && (b || j);
        e.wrong = 1'b0;
        if (is_cf && (actual != ptk)) e.wrong = 1'b1;
        if (is_cf && actual && (tgt != ptgt)) e.wrong = 1'b1;
        if (v && !b && !j && ptk) e.wrong = 1'b1;
        e.redir = actual ? tgt : pex + 32'd4;
        e.cnt   = 16'(m_cnt);
        if (do_update) begin
            i = int'(pex[5:2]);
            if (is_cf) begin
                if (j) begin
                    m_ctr[i] = 3; m_val[i] = 1'b1; m_tag[i] = pex[31:6]; m_tgt[i] = tgt;
                end else if (tk) begin
                    m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    m_val[i] = 1'b1; m_tag[i] = pex[31:6]; m_tgt[i] = tgt;
                end else begin
                    m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                end
            end else if (v && ptk) begin
                m_val[i] = 1'b0;
            end
            if (e.wrong && m_cnt < 65535) m_cnt++;
        end
        return e;
    endfunction

    task automatic step(input logic [31:0] pif, input logic v, b, j, input logic [31:0] pex,
                        input logic tk, input logic [31:0] tgt, input logic ptk,
                        input logic [31:0] ptgt, input bit push);
        exp_t e;
        @(posedge clk);
        #1;
        pc_if = pif; ex_valid = v; branch_ex = b; jump_ex = j; pc_ex = pex;
        taken_ex = tk; target_ex = tgt; pred_taken_ex = ptk; pred_target_ex = ptgt;
        e = model_step(pif, v, b, j, pex, tk, tgt, ptk, ptgt, 1'b1);
        if (push) exp_q.push_back(e);
    endtask

    // Monitor: compare whatever the DUT presents against the oldest queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("predict_taken_if", {31'd0, predict_taken_if}, {31'd0, e.ptk});
            chk("predict_target_if", predict_target_if, e.ptgt);
            chk("wrong_prediction", {31'd0, wrong_prediction}, {31'd0, e.wrong});
            if (e.wrong) chk("redirect_pc", redirect_pc, e.redir);
            chk("mispredict_count", {16'd0, mispredict_count}, {16'd0, e.cnt});
        end
    end

    initial begin
        logic [31:0] pif, pex, tgt, ptgt;
        logic        v, b, j, tk, ptk;
        int          kind;
        exp_t        e;

        // Reset held across an edge while a jump sits in EX: outputs live, no training
        model_reset();
        reset = 1'b1;
        pc_if = 32'h40; ex_valid = 1'b1; branch_ex = 1'b0; jump_ex = 1'b1; pc_ex = 32'h40;
        taken_ex = 1'b0; target_ex = 32'h80; pred_taken_ex = 1'b0; pred_target_ex = 32'h44;
        e = model_step(32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h80, 1'b0, 32'h44, 1'b0);
        exp_q.push_back(e);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ex_valid = 1'b0; jump_ex = 1'b0;

        // Table untouched by the discarded update
        step(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // Taken branch predicted not taken, then lookup sees WT with target
        step(32'h40, 1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 32'h80, 1'b0, 32'h44, 1'b1);
        step(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // Same branch not taken twice while predicted taken
        step(32'h40, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1);
        step(32'h40, 1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h80, 1'b1, 32'h80, 1'b1);
        step(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // Jump with right direction, wrong target
        step(32'h100, 1'b1, 1'b0, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h180, 1'b1);
        step(32'h100, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // Bubble carrying a mismatched branch: no flush, no training
        step(32'h240, 1'b0, 1'b1, 1'b0, 32'h240, 1'b1, 32'h300, 1'b0, 32'h244, 1'b1);
        step(32'h240, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // Lookup and update on the same slot: old value first, new value next cycle
        step(32'h40, 1'b1, 1'b0, 1'b1, 32'h40, 1'b0, 32'h90, 1'b0, 32'h44, 1'b1);
        step(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // Stale alias: non-control instruction predicted taken clears the entry
        step(32'h40, 1'b1, 1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 1'b1, 32'h90, 1'b1);
        step(32'h40, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        // PC wrap at the top of the address space
        step(32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h10, 1'b1, 32'h10, 1'b1);

        // Randomized traffic over a few aliasing tags
        for (int n = 0; n < 400; n++) begin
            pif  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            pex  = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            kind = int'($urandom_range(0, 4));
            v    = (kind != 0) || ($urandom_range(0, 1) == 1);
            b    = (kind == 1) || (kind == 2) || (kind == 0);
            j    = (kind == 3);
            tk   = $urandom_range(0, 1) == 1;
            tgt  = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_FFFC) : (32'h400 | ($urandom_range(0, 3) << 2));
            if ($urandom_range(0, 1) == 1) begin
                model_predict(pex, ptk, ptgt);
            end else begin
                ptk  = $urandom_range(0, 1) == 1;
                ptgt = ptk ? (32'h400 | ($urandom_range(0, 3) << 2)) : pex + 32'd4;
            end
            step(pif, v, b, j, pex, tk, tgt, ptk, ptgt, 1'b1);
        end

        // Drive the statistics counter up to 0xFFFE, then check saturation
        while (m_cnt < 16'hFFFE) begin
            step(32'h3000, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
        end
        for (int n = 0; n < 3; n++) begin
            step(32'h3000, 1'b1, 1'b0, 1'b0, 32'h3000, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1);
        end
        step(32'h3000, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Drain the scoreboard with a bounded wait
        for (int n = 0; n < 20 && exp_q.size() > 0; n++) @(negedge clk);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
